// File: rtl/mixer_pkg.sv
// Shared constants, enums and the per-voice amplitude mapping for the note mixer.
package mixer_pkg;

    localparam int NUM_VOICES = 12;
    localparam int CNT_W      = 18;
    localparam int AMP_W      = 8;
    localparam int SUM_W      = 12;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SILENT = 2'd3
    } wave_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_ACC  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // q >= 128 folds back: 2*(255-q) == 2*(~q), truncated to 8 bits.
    function automatic logic [AMP_W-1:0] voice_amp(
        input logic             en,
        input wave_t            wave,
        input logic [AMP_W-1:0] q,
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] lim
    );
        logic [AMP_W-1:0] a;
        a = '0;
        if (en) begin
            case (wave)
                WAVE_SQUARE: a = (lim != '0 && cnt <= (lim >> 1)) ? '1 : '0;
                WAVE_SAW:    a = q;
                WAVE_TRI:    a = q[AMP_W-1] ? {~q[AMP_W-2:0], 1'b0} : {q[AMP_W-2:0], 1'b0};
                default:     a = '0;
            endcase
        end
        return a;
    endfunction

endpackage

// File: rtl/phase_div.sv
// 8-iteration restoring divider: q = floor(cnt*256/(lim+1)), with the
// lim==0 -> 0 and cnt>lim -> 255 cases resolved at start. done pulses once after 8 cycles.
module phase_div
    import mixer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] lim,
    output logic [AMP_W-1:0] q,
    output logic             done
);

    logic [CNT_W-1:0] rem;
    logic [CNT_W:0]   dvs;
    logic [CNT_W:0]   shifted;
    logic [3:0]       iter;
    logic             fixed;

    // rem < dvs always, so the shifted remainder never exceeds CNT_W+1 bits
    assign shifted = {rem, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            dvs   <= '0;
            iter  <= '0;
            fixed <= 1'b0;
            q     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= cnt;
                dvs   <= {1'b0, lim} + (CNT_W+1)'(1);
                iter  <= 4'd8;
                fixed <= (lim == '0) || (cnt > lim);
                q     <= (lim == '0) ? '0 : ((cnt > lim) ? '1 : '0);
            end else if (iter != 4'd0) begin
                iter <= iter - 4'd1;
                done <= (iter == 4'd1);
                if (!fixed) begin
                    if (shifted >= dvs) begin
                        rem <= CNT_W'(shifted - dvs);
                        q   <= {q[AMP_W-2:0], 1'b1};
                    end else begin
                        rem <= shifted[CNT_W-1:0];
                        q   <= {q[AMP_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/note_mixer.sv
// Twelve-voice note mixer: one sample per SAMPLE_DIV clocks, 109-cycle voice scan.
// MIX_SATURATE_EN selects min(sum>>2,255) output instead of sum>>4. n_rst is active-high.
module note_mixer
    import mixer_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [NUM_VOICES*CNT_W-1:0] cnt_in,
    input  logic [NUM_VOICES*CNT_W-1:0] lim_in,
    input  logic [NUM_VOICES-1:0]       key_en,
    input  logic [1:0]                  wave_sel,
    output logic [AMP_W-1:0]            sample,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic                        busy,
    output logic                        overrun
);

    logic [NUM_VOICES-1:0][CNT_W-1:0] cnt_v, lim_v;
    state_t           state;
    logic [15:0]      tick_cnt;
    logic             tick;
    logic [3:0]       voice;
    logic [2:0]       div_cyc;
    logic [CNT_W-1:0] cnt_r, lim_r;
    logic             en_r;
    wave_t            wave_r;
    logic [SUM_W-1:0] sum, sum_next;
    logic [AMP_W-1:0] q, amp, mix;
    logic             div_start, div_done;

    assign cnt_v = cnt_in;
    assign lim_v = lim_in;
    assign tick  = (tick_cnt == 16'(SAMPLE_DIV - 1));
    assign busy  = (state == ST_LOAD) || (state == ST_DIV) || (state == ST_ACC);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
    end

    assign div_start = (state == ST_LOAD);

    phase_div u_div (
        .clk   (clk),
        .rst   (n_rst),
        .start (div_start),
        .cnt   (cnt_v[voice]),
        .lim   (lim_v[voice]),
        .q     (q),
        .done  (div_done)
    );

    // A voice's quotient lands during the following LOAD (or ACC for voice 11),
    // while cnt_r/lim_r/en_r/wave_r still describe that voice.
    always_comb begin
        amp      = voice_amp(en_r, wave_r, q, cnt_r, lim_r);
        sum_next = sum + (div_done ? SUM_W'(amp) : '0);
`ifdef MIX_SATURATE_EN
        mix = (sum_next[SUM_W-1:10] != '0) ? '1 : sum_next[9:2];
`else
        mix = sum_next[SUM_W-1:4];
`endif
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state        <= ST_IDLE;
            voice        <= '0;
            div_cyc      <= '0;
            cnt_r        <= '0;
            lim_r        <= '0;
            en_r         <= 1'b0;
            wave_r       <= WAVE_SQUARE;
            sum          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // Only IDLE can accept a tick; everything else (incl. a completing handshake) loses it
            if (tick && state != ST_IDLE) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_LOAD;
                        voice <= '0;
                        sum   <= '0;
                    end
                end
                ST_LOAD: begin
                    cnt_r   <= cnt_v[voice];
                    lim_r   <= lim_v[voice];
                    en_r    <= key_en[voice];
                    wave_r  <= wave_t'(wave_sel);
                    sum     <= sum_next;
                    div_cyc <= '0;
                    state   <= ST_DIV;
                end
                ST_DIV: begin
                    div_cyc <= div_cyc + 3'd1;
                    if (div_cyc == 3'd7) begin
                        if (voice == 4'(NUM_VOICES - 1)) begin
                            state <= ST_ACC;
                        end else begin
                            voice <= voice + 4'd1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_ACC: begin
                    sum          <= sum_next;
                    sample       <= mix;
                    sample_valid <= 1'b1;
                    state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (sample_valid && sample_ready) begin
                        sample_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_mixer.sv
// Directed bench for note_mixer: reset, waveform mapping, latency, overrun and handshake.
module tb_note_mixer;

    localparam int DIV = 200;

`ifdef MIX_SATURATE_EN
    localparam logic [7:0] EXP_SAW9  = 8'h20;
    localparam logic [7:0] EXP_SQALL = 8'hFF;
    localparam logic [7:0] EXP_TRI0  = 8'h0C;
    localparam logic [7:0] EXP_CLIP3 = 8'h3F;
`else
    localparam logic [7:0] EXP_SAW9  = 8'h08;
    localparam logic [7:0] EXP_SQALL = 8'hBF;
    localparam logic [7:0] EXP_TRI0  = 8'h03;
    localparam logic [7:0] EXP_CLIP3 = 8'h0F;
`endif

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic [215:0] cnt_in = '0;
    logic [215:0] lim_in = '0;
    logic [11:0]  key_en = '0;
    logic [1:0]   wave_sel = 2'd0;
    logic         sample_ready = 1'b1;
    logic [7:0]   sample;
    logic         sample_valid, busy, overrun;

    int errors = 0;
    int checks = 0;
    int tb_cnt;

    note_mixer #(.SAMPLE_DIV(DIV)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cnt_in       (cnt_in),
        .lim_in       (lim_in),
        .key_en       (key_en),
        .wave_sel     (wave_sel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference tick position: the cycle in which this count equals DIV-1
    always @(posedge clk or posedge n_rst) begin
        if (n_rst) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == DIV - 1) ? 0 : tb_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_voices();
        cnt_in = '0;
        lim_in = '0;
        key_en = '0;
    endtask

    task automatic set_voice(input int v, input logic [17:0] c, input logic [17:0] l);
        cnt_in[v*18 +: 18] = c;
        lim_in[v*18 +: 18] = l;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2*DIV + 4; i++) begin
            @(posedge clk); #1;
            if (tb_cnt == DIV - 1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // From the tick cycle: busy for 109 scan cycles, valid in the cycle after the last one.
    task automatic scan_check(input string nm, input logic [7:0] exp);
        bit ok;
        int n;
        wait_tick(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_tick: no tick seen within %0d cycles", nm, 2*DIV + 4);
            return;
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: busy=%b after tick, expected 1", nm, busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n !== 109) begin
            errors++;
            $display("FAIL %s_scan_len: busy for %0d cycles, expected 109", nm, n);
        end
        checks++;
        if (sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: sample_valid=%b after scan, expected 1", nm, sample_valid);
        end
        checks++;
        if (sample !== exp) begin
            errors++;
            $display("FAIL %s_sample: got 0x%02h expected 0x%02h", nm, sample, exp);
        end
    endtask

    // With ready high the handshake completes on the first valid cycle.
    task automatic check_drop(input string nm);
        @(posedge clk); #1;
        checks++;
        if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drop: valid=%b busy=%b, expected 0 0", nm, sample_valid, busy);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sample, sample_valid, busy, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: sample=0x%02h valid=%b busy=%b overrun=%b, expected all 0",
                     sample, sample_valid, busy, overrun);
        end
        n_rst = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        bit ok;
        clear_voices();
        set_voice(9, 18'd500, 18'd999);
        key_en[9] = 1'b1;
        wave_sel = 2'd1;
        sample_ready = 1'b1;
        wait_tick(ok);
        repeat (50) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: tick_seen=%b busy=%b, expected 1 1", ok, busy);
        end
        n_rst = 1'b1;
        #1;
        checks++;
        if ({sample, sample_valid, busy, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_outputs: sample=0x%02h valid=%b busy=%b overrun=%b, expected all 0",
                     sample, sample_valid, busy, overrun);
        end
        @(posedge clk); #1;
        n_rst = 1'b0;
        scan_check("midrst_rescan", EXP_SAW9);
        check_drop("midrst_rescan");
    endtask

    task automatic test_saw_v9();
        clear_voices();
        set_voice(9, 18'd500, 18'd999);
        key_en[9] = 1'b1;
        wave_sel = 2'd1;
        scan_check("saw9", EXP_SAW9);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL saw9_overrun: overrun=%b expected 0", overrun);
        end
        check_drop("saw9");
    endtask

    task automatic test_square_all();
        clear_voices();
        for (int v = 0; v < 12; v++) set_voice(v, 18'd0, 18'd100);
        key_en = '1;
        wave_sel = 2'd0;
        scan_check("square_all", EXP_SQALL);
        check_drop("square_all");
    endtask

    task automatic test_triangle_v0();
        clear_voices();
        set_voice(0, 18'd900, 18'd999);
        key_en[0] = 1'b1;
        wave_sel = 2'd2;
        scan_check("tri0", EXP_TRI0);
        check_drop("tri0");
    endtask

    task automatic test_boundaries();
        clear_voices();
        key_en[3] = 1'b1;
        set_voice(3, 18'd5, 18'd0);
        wave_sel = 2'd0;
        scan_check("sq_lim0", 8'h00);
        check_drop("sq_lim0");
        set_voice(3, 18'd0, 18'd0);
        wave_sel = 2'd1;
        scan_check("saw_lim0", 8'h00);
        check_drop("saw_lim0");
        set_voice(3, 18'd1200, 18'd999);
        scan_check("saw_clip", EXP_CLIP3);
        check_drop("saw_clip");
        key_en[3] = 1'b0;
        scan_check("disabled", 8'h00);
        check_drop("disabled");
        key_en[3] = 1'b1;
        wave_sel = 2'd3;
        scan_check("silence", 8'h00);
        check_drop("silence");
    endtask

    task automatic test_overrun();
        logic [7:0] held;
        int unstable;
        bit ok;
        clear_voices();
        set_voice(9, 18'd500, 18'd999);
        key_en[9] = 1'b1;
        wave_sel = 2'd1;
        sample_ready = 1'b0;
        scan_check("ovr_scan", EXP_SAW9);
        held = sample;
        unstable = 0;
        ok = 1'b0;
        for (int i = 0; i < 2*DIV + 4; i++) begin
            @(posedge clk); #1;
            if (sample !== held || sample_valid !== 1'b1) unstable++;
            if (tb_cnt == DIV - 1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || unstable != 0) begin
            errors++;
            $display("FAIL ovr_hold: tick_seen=%b unstable_cycles=%0d, expected 1 0", ok, unstable);
        end
        @(posedge clk); #1;
        checks++;
        if (overrun !== 1'b1 || sample_valid !== 1'b1 || busy !== 1'b0 || sample !== held) begin
            errors++;
            $display("FAIL ovr_set: overrun=%b valid=%b busy=%b sample=0x%02h, expected 1 1 0 0x%02h",
                     overrun, sample_valid, busy, sample, held);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: overrun=%b expected 1", overrun);
        end
        sample_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_release: valid=%b busy=%b overrun=%b, expected 0 0 1",
                     sample_valid, busy, overrun);
        end
        scan_check("ovr_after", EXP_SAW9);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_after_sticky: overrun=%b expected 1", overrun);
        end
        check_drop("ovr_after");
    endtask

    task automatic test_tick_handshake();
        bit ok;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL coinc_reset: overrun=%b expected 0", overrun);
        end
        n_rst = 1'b0;
        sample_ready = 1'b0;
        scan_check("coinc_scan", EXP_SAW9);
        wait_tick(ok);
        // Handshake completes in the very cycle the tick fires
        sample_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!ok || sample_valid !== 1'b0 || overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coinc_drop: tick_seen=%b valid=%b overrun=%b busy=%b, expected 1 0 1 0",
                     ok, sample_valid, overrun, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL coinc_no_scan: busy=%b expected 0", busy);
        end
        scan_check("coinc_next", EXP_SAW9);
        check_drop("coinc_next");
    endtask

    initial begin
        test_reset();
        test_reset_mid_scan();
        test_saw_v9();
        test_square_all();
        test_triangle_v0();
        test_boundaries();
        test_overrun();
        test_tick_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
